// File: rtl/pf_iod_lvds_rx_train_pkg.sv
// Shared types and helpers for the LVDS RX lane training controller.
package pf_iod_lvds_rx_train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_STEP,
    ST_CALC,
    ST_RELOAD,
    ST_RL_GAP,
    ST_RL_MOVE,
    ST_SETTLE2,
    ST_ALIGN,
    ST_SLIP,
    ST_DONE,
    ST_FAIL
  } train_state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_NO_WINDOW = 2'd1;
  localparam logic [1:0] ERR_NO_ALIGN  = 2'd2;

  function automatic int tap_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // States in which the controller is parked and will accept TRAIN_START.
  function automatic logic is_quiet(input train_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAIL);
  endfunction

endpackage

// File: rtl/pf_iod_lvds_rx_rot_match.sv
// Combinational compare of a deserialized word against a training pattern:
// any cyclic rotation of it, and exact equality.
module pf_iod_lvds_rx_rot_match #(
  parameter int                WORD_W  = 8,
  parameter logic [WORD_W-1:0] PATTERN = 8'h68
) (
  input  logic [WORD_W-1:0] data_i,
  output logic              any_rot_o,
  output logic              exact_o
);

  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v, input int r);
    logic [2*WORD_W-1:0] dbl;
    dbl = {v, v} << r;
    return dbl[2*WORD_W-1:WORD_W];
  endfunction

  always_comb begin
    any_rot_o = 1'b0;
    for (int r = 0; r < WORD_W; r++) begin
      if (data_i == rotl(PATTERN, r)) any_rot_o = 1'b1;
    end
  end

  assign exact_o = (data_i == PATTERN);

endmodule

// File: rtl/pf_iod_lvds_rx_lane_train.sv
// LVDS RX lane trainer: sweeps the delay line, parks it at the centre of the
// widest clean window, then bit-slips until the word equals TRAIN_PATTERN.
module pf_iod_lvds_rx_lane_train
  import pf_iod_lvds_rx_train_pkg::*;
#(
  parameter int                WORD_W        = 8,
  parameter logic [WORD_W-1:0] TRAIN_PATTERN = 8'h68,
  parameter int                NUM_TAPS      = 128,
  parameter int                SETTLE_CYC    = 4,
  parameter int                MATCH_CNT     = 16,
  localparam int               TAP_W         = tap_w(NUM_TAPS)
) (
  input  logic              FAB_CLK,
  input  logic              ARST_N,
  // Single-cycle request, sampled only while the controller is parked
  // (IDLE/DONE/FAIL); pulses while TRAIN_BUSY is high are dropped.
  input  logic              TRAIN_START,
  input  logic [WORD_W-1:0] RX_DATA,
  input  logic              TX_DELAY_LINE_OUT_OF_RANGE,
  output logic              DELAY_LINE_LOAD,
  output logic              DELAY_LINE_MOVE,
  output logic              DELAY_LINE_DIRECTION,
  output logic              RX_BIT_SLIP,
  output logic              TRAIN_BUSY,
  output logic              TRAIN_DONE,
  output logic [1:0]        TRAIN_ERR,
  output logic [TAP_W-1:0]  TAP_CENTER,
  output logic [TAP_W:0]    WINDOW_WIDTH,
  output logic [3:0]        DBG_STATE
);

  localparam int SET_W = tap_w(SETTLE_CYC + 1);
  localparam int SMP_W = tap_w(2 * MATCH_CNT);
  localparam int GC_W  = tap_w(MATCH_CNT + 1);
  localparam int SL_W  = tap_w(WORD_W);

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(2 * MATCH_CNT - 1);
  localparam logic [GC_W-1:0]  GC_MAX   = GC_W'(MATCH_CNT);
  localparam logic [SL_W-1:0]  SL_MAX   = SL_W'(WORD_W - 1);
  localparam logic [TAP_W:0]   LEN_ONE  = {{TAP_W{1'b0}}, 1'b1};

  train_state_t      state_q, state_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [SMP_W-1:0]  samp_cnt_q, samp_cnt_d;
  logic [GC_W-1:0]   good_cnt_q, good_cnt_d;
  logic [WORD_W-1:0] prev_q;
  logic              tap_good_q, tap_good_d;
  logic              run_open_q, run_open_d;
  logic [TAP_W-1:0]  run_first_q, run_first_d;
  logic [TAP_W:0]    run_len_q, run_len_d;
  logic [TAP_W-1:0]  best_first_q, best_first_d;
  logic [TAP_W:0]    best_len_q, best_len_d;
  logic [TAP_W-1:0]  center_q, center_d;
  logic [TAP_W-1:0]  mv_cnt_q, mv_cnt_d;
  logic [SL_W-1:0]   slip_cnt_q, slip_cnt_d;
  logic              oor_seen_q, oor_seen_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [TAP_W-1:0]  tap_center_q, tap_center_d;
  logic [TAP_W:0]    win_width_q, win_width_d;
  logic              load_q, load_d;
  logic              move_q, move_d;
  logic              slip_q, slip_d;

  logic              any_match, exact_match;
  logic              word_ok, hit, reached, last_tap;
  logic [GC_W-1:0]   good_next;
  logic [TAP_W-1:0]  cur_first;
  logic [TAP_W:0]    cur_len;

  pf_iod_lvds_rx_rot_match #(
    .WORD_W  (WORD_W),
    .PATTERN (TRAIN_PATTERN)
  ) u_rot_match (
    .data_i    (RX_DATA),
    .any_rot_o (any_match),
    .exact_o   (exact_match)
  );

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q      <= ST_IDLE;
      tap_q        <= '0;
      settle_cnt_q <= '0;
      samp_cnt_q   <= '0;
      good_cnt_q   <= '0;
      prev_q       <= '0;
      tap_good_q   <= 1'b0;
      run_open_q   <= 1'b0;
      run_first_q  <= '0;
      run_len_q    <= '0;
      best_first_q <= '0;
      best_len_q   <= '0;
      center_q     <= '0;
      mv_cnt_q     <= '0;
      slip_cnt_q   <= '0;
      oor_seen_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= ERR_NONE;
      tap_center_q <= '0;
      win_width_q  <= '0;
      load_q       <= 1'b0;
      move_q       <= 1'b0;
      slip_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      settle_cnt_q <= settle_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      good_cnt_q   <= good_cnt_d;
      prev_q       <= RX_DATA;
      tap_good_q   <= tap_good_d;
      run_open_q   <= run_open_d;
      run_first_q  <= run_first_d;
      run_len_q    <= run_len_d;
      best_first_q <= best_first_d;
      best_len_q   <= best_len_d;
      center_q     <= center_d;
      mv_cnt_q     <= mv_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      oor_seen_q   <= oor_seen_d;
      done_q       <= done_d;
      err_q        <= err_d;
      tap_center_q <= tap_center_d;
      win_width_q  <= win_width_d;
      load_q       <= load_d;
      move_q       <= move_d;
      slip_q       <= slip_d;
    end
  end

  // A word counts only when stable across two cycles; the sweep accepts any
  // rotation of the pattern, the alignment step only the exact pattern.
  always_comb begin
    word_ok   = (state_q == ST_ALIGN) ? exact_match : any_match;
    hit       = word_ok && (RX_DATA == prev_q);
    good_next = '0;
    if (hit) good_next = (good_cnt_q == GC_MAX) ? GC_MAX : good_cnt_q + 1'b1;
    reached   = (good_next == GC_MAX);
    last_tap  = (tap_q == LAST_TAP) || oor_seen_q || TX_DELAY_LINE_OUT_OF_RANGE;
    cur_first = run_first_q;
    cur_len   = run_len_q;
    if (tap_good_q) begin
      if (run_open_q) begin
        if (run_len_q != '1) cur_len = run_len_q + 1'b1;
      end else begin
        cur_first = tap_q;
        cur_len   = LEN_ONE;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    settle_cnt_d = '0;
    samp_cnt_d   = '0;
    good_cnt_d   = '0;
    tap_good_d   = tap_good_q;
    run_open_d   = run_open_q;
    run_first_d  = run_first_q;
    run_len_d    = run_len_q;
    best_first_d = best_first_q;
    best_len_d   = best_len_q;
    center_d     = center_q;
    mv_cnt_d     = mv_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    oor_seen_d   = oor_seen_q;
    done_d       = done_q;
    err_d        = err_q;
    tap_center_d = tap_center_q;
    win_width_d  = win_width_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (TRAIN_START) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        tap_d        = '0;
        run_open_d   = 1'b0;
        run_first_d  = '0;
        run_len_d    = '0;
        best_first_d = '0;
        best_len_d   = '0;
        oor_seen_d   = 1'b0;
        slip_cnt_d   = '0;
        done_d       = 1'b0;
        err_d        = ERR_NONE;
        tap_center_d = '0;
        win_width_d  = '0;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE, ST_SETTLE2: begin
        if (state_q == ST_SETTLE) oor_seen_d = oor_seen_q | TX_DELAY_LINE_OUT_OF_RANGE;
        if (settle_cnt_q == SET_LAST) begin
          state_d = (state_q == ST_SETTLE) ? ST_SAMPLE : ST_ALIGN;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        oor_seen_d = oor_seen_q | TX_DELAY_LINE_OUT_OF_RANGE;
        good_cnt_d = good_next;
        if (reached) begin
          tap_good_d = 1'b1;
          state_d    = ST_EVAL;
        end else if (samp_cnt_q == SMP_LAST) begin
          tap_good_d = 1'b0;
          state_d    = ST_EVAL;
        end else begin
          samp_cnt_d = samp_cnt_q + 1'b1;
        end
      end
      ST_EVAL: begin
        // Runs close on a bad tap or at the end of the sweep; a strictly
        // longer run is needed to displace the earlier best window.
        if (!tap_good_q || last_tap) begin
          if (cur_len > best_len_q) begin
            best_first_d = cur_first;
            best_len_d   = cur_len;
          end
          run_open_d = 1'b0;
          run_len_d  = '0;
        end else begin
          run_open_d  = 1'b1;
          run_first_d = cur_first;
          run_len_d   = cur_len;
        end
        state_d = last_tap ? ST_CALC : ST_STEP;
      end
      ST_STEP: begin
        if (tap_q != LAST_TAP) tap_d = tap_q + 1'b1;
        state_d = ST_SETTLE;
      end
      ST_CALC: begin
        if (best_len_q == '0) begin
          err_d   = ERR_NO_WINDOW;
          state_d = ST_FAIL;
        end else begin
          center_d     = best_first_q + TAP_W'((best_len_q - 1'b1) >> 1);
          tap_center_d = best_first_q + TAP_W'((best_len_q - 1'b1) >> 1);
          win_width_d  = best_len_q;
          state_d      = ST_RELOAD;
        end
      end
      ST_RELOAD: begin
        tap_d      = '0;
        mv_cnt_d   = '0;
        slip_cnt_d = '0;
        state_d    = (center_q == '0) ? ST_SETTLE2 : ST_RL_GAP;
      end
      ST_RL_GAP: state_d = ST_RL_MOVE;
      ST_RL_MOVE: begin
        if (tap_q != LAST_TAP) tap_d = tap_q + 1'b1;
        mv_cnt_d = mv_cnt_q + 1'b1;
        state_d  = (mv_cnt_q + 1'b1 == center_q) ? ST_SETTLE2 : ST_RL_GAP;
      end
      ST_ALIGN: begin
        good_cnt_d = good_next;
        if (reached) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (samp_cnt_q == SMP_LAST) begin
          if (slip_cnt_q != SL_MAX) begin
            slip_cnt_d = slip_cnt_q + 1'b1;
            state_d    = ST_SLIP;
          end else begin
            err_d   = ERR_NO_ALIGN;
            state_d = ST_FAIL;
          end
        end else begin
          samp_cnt_d = samp_cnt_q + 1'b1;
        end
      end
      ST_SLIP: state_d = ST_SETTLE2;
      default: state_d = ST_IDLE;
    endcase

    // Pulses are registered against the next state so each one is high for
    // exactly the cycle its owning state occupies; states never overlap.
    load_d = (state_d == ST_LOAD) || (state_d == ST_RELOAD);
    move_d = (state_d == ST_STEP) || (state_d == ST_RL_MOVE);
    slip_d = (state_d == ST_SLIP);
  end

  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = move_q;
  assign RX_BIT_SLIP          = slip_q;
  assign TRAIN_BUSY           = !is_quiet(state_q);
  assign TRAIN_DONE           = done_q;
  assign TRAIN_ERR            = err_q;
  assign TAP_CENTER           = tap_center_q;
  assign WINDOW_WIDTH         = win_width_q;
  assign DBG_STATE            = state_q;

endmodule

// File: tb/tb_pf_iod_lvds_rx_lane_train.sv
// Directed bench: behavioural lane model, driver tasks, and a scoreboard that
// checks each completed training run against a hand-computed result record.
module tb_pf_iod_lvds_rx_lane_train;

  localparam int NT = 128;
  localparam int RW = 43;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N = 1'b1;
  logic       TRAIN_START = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       OOR = 1'b0;
  logic       LOAD, MOVE, DIR, SLIP, BUSY, DONE;
  logic [1:0] ERR;
  logic [6:0] CENTER;
  logic [7:0] WIDTH;
  logic [3:0] DBG_STATE;

  pf_iod_lvds_rx_lane_train dut (
    .FAB_CLK                    (FAB_CLK),
    .ARST_N                     (ARST_N),
    .TRAIN_START                (TRAIN_START),
    .RX_DATA                    (RX_DATA),
    .TX_DELAY_LINE_OUT_OF_RANGE (OOR),
    .DELAY_LINE_LOAD            (LOAD),
    .DELAY_LINE_MOVE            (MOVE),
    .DELAY_LINE_DIRECTION       (DIR),
    .RX_BIT_SLIP                (SLIP),
    .TRAIN_BUSY                 (BUSY),
    .TRAIN_DONE                 (DONE),
    .TRAIN_ERR                  (ERR),
    .TAP_CENTER                 (CENTER),
    .WINDOW_WIDTH               (WIDTH),
    .DBG_STATE                  (DBG_STATE)
  );

  // Clock
  initial forever #5 FAB_CLK = ~FAB_CLK;

  int n_checks = 0;
  int n_fail = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack_res(input int chk_cw, input int done, input int err,
                                             input int center, input int width, input int slips,
                                             input int rl, input int sw, input int loads);
    return {chk_cw[0], done[0], err[1:0], center[6:0], width[7:0], slips[3:0],
            rl[7:0], sw[7:0], loads[3:0]};
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int r);
    return (v << r) | (v >> (8 - r));
  endfunction

  // Lane model: mode 0 = window data rotated by 3 and un-rotated by slips,
  // mode 1 = random everywhere, mode 2 = window data rotated by 1, slips ignored.
  int cfg_mode = 1;
  int w1_lo = NT, w1_hi = -1, w2_lo = NT, w2_hi = -1, oor_tap = NT;
  int m_tap = 0, m_slips = 0;

  initial begin
    int rot;
    forever begin
      @(negedge FAB_CLK);
      if (!ARST_N) begin
        m_tap = 0;
        m_slips = 0;
      end else begin
        if (LOAD) begin
          m_tap = 0;
          m_slips = 0;
        end
        if (MOVE && m_tap < NT - 1) m_tap++;
        if (SLIP) m_slips++;
      end
      OOR = (m_tap >= oor_tap);
      if (cfg_mode != 1 && ((m_tap >= w1_lo && m_tap <= w1_hi) || (m_tap >= w2_lo && m_tap <= w2_hi))) begin
        rot = (cfg_mode == 2) ? 1 : ((m_slips >= 3) ? 0 : 3 - m_slips);
        RX_DATA = rotl8(8'h68, rot);
      end else begin
        RX_DATA = 8'($urandom_range(0, 255));
      end
    end
  end

  // Monitor: counts pulses per run and scores each run when BUSY falls.
  int c_loads = 0, c_rl = 0, c_sw = 0, c_slip = 0;
  logic prev_busy = 1'b0;

  initial begin
    logic [RW-1:0] e;
    forever begin
      @(negedge FAB_CLK);
      if (!ARST_N) begin
        prev_busy = 1'b0;
        c_loads = 0; c_rl = 0; c_sw = 0; c_slip = 0;
      end else begin
        check("pulse_overlap", int'(LOAD) + int'(MOVE) + int'(SLIP) > 1, 0);
        check("direction_vs_move", DIR, MOVE);
        if (BUSY && !prev_busy) begin
          c_loads = 0; c_rl = 0; c_sw = 0; c_slip = 0;
        end
        if (LOAD) c_loads++;
        if (MOVE) begin
          if (c_loads >= 2) c_rl++;
          else c_sw++;
        end
        if (SLIP) c_slip++;
        if (!BUSY && prev_busy) begin
          check("completion_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("train_done", DONE, int'(e[41]));
            check("train_err", ERR, int'(e[40:39]));
            if (e[42]) begin
              check("tap_center", CENTER, int'(e[38:32]));
              check("window_width", WIDTH, int'(e[31:24]));
            end
            check("bit_slips", c_slip, int'(e[23:20]));
            check("reload_moves", c_rl, int'(e[19:12]));
            check("sweep_moves", c_sw, int'(e[11:4]));
            check("load_pulses", c_loads, int'(e[3:0]));
          end
        end
        prev_busy = BUSY;
      end
    end
  end

  // Driver tasks
  task automatic start_train();
    @(negedge FAB_CLK);
    TRAIN_START = 1'b1;
    @(negedge FAB_CLK);
    TRAIN_START = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (BUSY && cyc < 20000) begin
      @(negedge FAB_CLK);
      cyc++;
    end
    check("train_timeout", BUSY, 0);
    repeat (4) @(negedge FAB_CLK);
  endtask

  task automatic set_cfg(input int mode, input int a_lo, input int a_hi,
                         input int b_lo, input int b_hi, input int oor_at);
    cfg_mode = mode;
    w1_lo = a_lo; w1_hi = a_hi;
    w2_lo = b_lo; w2_hi = b_hi;
    oor_tap = oor_at;
  endtask

  task automatic run_case(input logic [RW-1:0] expected);
    exp_q.push_back(expected);
    start_train();
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load"}, LOAD, 0);
    check({tag, "_move"}, MOVE, 0);
    check({tag, "_dir"}, DIR, 0);
    check({tag, "_slip"}, SLIP, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_done"}, DONE, 0);
    check({tag, "_err"}, ERR, 0);
    check({tag, "_center"}, CENTER, 0);
    check({tag, "_width"}, WIDTH, 0);
    check({tag, "_state"}, DBG_STATE, 0);
  endtask

  initial begin
    bit found;
    #2 ARST_N = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge FAB_CLK);
    ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);

    // 1: single window 40..79, three slips to align
    set_cfg(0, 40, 79, NT, -1, NT);
    run_case(pack_res(1, 1, 0, 59, 40, 3, 59, 127, 2));

    // 2: equal windows 10..29 and 90..109, earlier one kept
    set_cfg(0, 10, 29, 90, 109, NT);
    run_case(pack_res(1, 1, 0, 19, 20, 3, 19, 127, 2));

    // 3: random data everywhere, no window
    set_cfg(1, NT, -1, NT, -1, NT);
    run_case(pack_res(0, 0, 1, 0, 0, 0, 0, 127, 1));

    // 4: window 100..127, delay line saturates at tap 110
    set_cfg(0, 100, 127, NT, -1, 110);
    run_case(pack_res(1, 1, 0, 105, 11, 3, 105, 110, 2));

    // 5: window data never becomes exact under slipping
    set_cfg(2, 40, 79, NT, -1, NT);
    run_case(pack_res(0, 0, 2, 59, 40, 7, 59, 127, 2));

    // 6: reset during the STEP at tap 50, restart, ignored mid-run request
    set_cfg(0, 40, 79, NT, -1, NT);
    start_train();
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(posedge FAB_CLK);
      #2;
      if (MOVE && m_tap == 50) found = 1'b1;
    end
    check("reach_step_tap50", found, 1);
    ARST_N = 1'b0;
    #1 check_all_zero("abort");
    repeat (3) @(negedge FAB_CLK);
    check("abort_hold_pulses", int'(LOAD) + int'(MOVE) + int'(SLIP), 0);
    ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);
    exp_q.push_back(pack_res(1, 1, 0, 59, 40, 3, 59, 127, 2));
    start_train();
    check("restart_load_pulse", LOAD, 1);
    check("restart_busy", BUSY, 1);
    repeat (300) @(negedge FAB_CLK);
    start_train();
    check("busy_after_ignored_start", BUSY, 1);
    wait_idle();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
